pc_gen_fetch: RTL and testbench
===============================

Name: pc_gen_fetch

Overview:
Program-counter generation and fetch-request stage. It drives pc_out, the 32-bit fetch PC consumed by the fetch/decode path and sampled by the pc_out monitor. It issues instruction-memory requests over a valid/ready handshake and advances sequentially on each accepted request. It applies branch/jump redirects from execute and traps misaligned targets and memory timeouts into a fault state.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded when a fault is cleared.
TIMEOUT_CYCLES, 16, consecutive unaccepted request cycles before a timeout fault (valid range 2..255).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_i  in  1  downstream stall; holds PC and suppresses requests.
imem_ready_i  in  1  instruction memory accepts the request this cycle.
imem_req_o  out  1  fetch request valid.
imem_addr_o  out  32  fetch address; always equals pc_out.
redirect_i  in  1  taken branch/jump from execute.
redirect_target_i  in  32  redirect target address.
fault_clear_i  in  1  exits FAULT and vectors to TRAP_VECTOR.
pc_out  out  32  current fetch PC, registered.
fire_o  out  1  combinational; imem_req_o & imem_ready_i & !redirect_i.
kill_o  out  1  registered one-cycle pulse after a redirect; flush the younger fetch.
misalign_o  out  1  sticky misaligned-target fault flag.
timeout_o  out  1  sticky imem timeout fault flag.
fault_pc_o  out  32  offending target or stalled address, captured on fault entry.

Behaviour:
- Reset values (async, rst_n=0): pc_out=RESET_VECTOR; state=BOOT; imem_req_o=0; kill_o=0; misalign_o=0; timeout_o=0; fault_pc_o=0; wait counter=0.
- States:
  - BOOT: one cycle, no request, then FETCH.
  - FETCH: imem_req_o = !stall_i.
  - FAULT: imem_req_o=0.
- Sequential advance in FETCH: if fire_o, then pc_out <= pc_out+4 next edge. Unsigned 32-bit add; 32'hFFFF_FFFC wraps to 0 with no flag.
- Stall: stall_i=1 holds pc_out, deasserts imem_req_o and resets the wait counter.
- Redirect priority, highest first: reset > fault_clear_i (in FAULT) > redirect_i > fire_o > hold.
- redirect_i in FETCH or BOOT, target aligned (target[1:0]==0):
  - pc_out <= target; kill_o=1 for exactly the next cycle.
  - Any same-cycle handshake is not counted: fire_o=0, no increment.
  - Applies regardless of stall_i.
- redirect_i with target misaligned:
  - pc_out unchanged; misalign_o <= 1; fault_pc_o <= target; state <= FAULT; kill_o pulses.
- Timeout:
  - Counter increments each FETCH cycle with imem_req_o=1 & imem_ready_i=0; clears on fire, stall or redirect.
  - On reaching TIMEOUT_CYCLES: timeout_o <= 1; fault_pc_o <= pc_out; state <= FAULT.
- FAULT: redirect_i is ignored. fault_clear_i causes pc_out <= TRAP_VECTOR, clears misalign_o and timeout_o, state <= FETCH. fault_pc_o holds its value until the next fault.
- Simultaneous fault_clear_i and redirect_i in FAULT: the clear wins.
- Reset asserted mid-operation: immediate return to reset values; an outstanding request is abandoned.

Optional Feature:
Macro RVC_EN.
- Defined: adds input is_compressed_i (1 bit, valid with fire_o). The increment is +2 when is_compressed_i=1, else +4. Alignment check uses target[0] only, so 2-byte targets are legal.
- Undefined: no is_compressed_i port; increment is always +4; check uses target[1:0].

Test Plan:
- Reset release, imem_ready_i=1 constant: pc_out=0x0 during BOOT, then 0x0,0x4,0x8,0xC on successive cycles; imem_req_o rises one cycle after BOOT.
- Stall for 3 cycles at pc_out=0x8: pc_out holds 0x8, imem_req_o=0, no timeout; resumes to 0xC after the stall drops.
- redirect_i with target 0x200 in the same cycle as fire at 0x10: next pc_out=0x200 (not 0x14), kill_o=1 for one cycle, then 0x204.
- redirect_i with target 0x202: misalign_o=1, fault_pc_o=0x202, imem_req_o=0; fault_clear_i gives pc_out=0x100 and misalign_o=0. With RVC_EN, 0x202 is accepted instead.
- imem_ready_i=0 for 16 cycles at pc_out=0x40: timeout_o=1 on the 16th, fault_pc_o=0x40; the same case with ready on the 15th cycle gives no fault.
- Start from pc_out=0xFFFF_FFFC with fire: pc_out becomes 0x0000_0000 with no fault. Assert rst_n=0 mid-stall: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pc_gen_fetch.sv
// PC generation and instruction fetch request stage with redirect and fault trapping.
// Optional compressed-instruction support is enabled by defining RVC_EN.
module pc_gen_fetch #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        imem_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic        fault_clear_i,
`ifdef RVC_EN
  input  logic        is_compressed_i,
`endif
  output logic [31:0] pc_out,
  output logic        fire_o,
  output logic        kill_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [31:0] fault_pc_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [31:0] fpc_q, fpc_d;
  logic [7:0]  wait_q, wait_d;

  logic        req;
  logic        fire;
  logic        bad_tgt;
  logic [31:0] inc;

  assign req  = (state_q == FETCH) && !stall_i;
  assign fire = req && imem_ready_i && !redirect_i;

`ifdef RVC_EN
  assign bad_tgt = redirect_target_i[0];
  assign inc     = is_compressed_i ? 32'd2 : 32'd4;
`else
  assign bad_tgt = |redirect_target_i[1:0];
  assign inc     = 32'd4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = 1'b0;
    mis_d   = mis_q;
    to_d    = to_q;
    fpc_d   = fpc_q;
    wait_d  = wait_q;
    unique case (state_q)
      FAULT: begin
        // Redirects are ignored here; only the clear leaves FAULT
        if (fault_clear_i) begin
          pc_d    = TRAP_VECTOR;
          mis_d   = 1'b0;
          to_d    = 1'b0;
          wait_d  = 8'd0;
          state_d = FETCH;
        end
      end
      BOOT, FETCH: begin
        if (redirect_i) begin
          kill_d = 1'b1;
          wait_d = 8'd0;
          if (bad_tgt) begin
            mis_d   = 1'b1;
            fpc_d   = redirect_target_i;
            state_d = FAULT;
          end else begin
            pc_d    = redirect_target_i;
            state_d = FETCH;
          end
        end else if (state_q == BOOT) begin
          state_d = FETCH;
        end else if (fire) begin
          pc_d   = pc_q + inc;
          wait_d = 8'd0;
        end else if (stall_i) begin
          wait_d = 8'd0;
        end else if (wait_q == WaitLast) begin
          to_d    = 1'b1;
          fpc_d   = pc_q;
          wait_d  = 8'd0;
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      fpc_q   <= 32'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      fpc_q   <= fpc_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign pc_out      = pc_q;
  assign fire_o      = fire;
  assign kill_o      = kill_q;
  assign misalign_o  = mis_q;
  assign timeout_o   = to_q;
  assign fault_pc_o  = fpc_q;

endmodule

// File: tb/tb_pc_gen_fetch.sv
// Directed self-checking bench for pc_gen_fetch (default build, 16-cycle timeout).
module tb_pc_gen_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        imem_ready_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        fault_clear_i;
  logic [31:0] pc_out;
  logic        fire_o;
  logic        kill_o;
  logic        misalign_o;
  logic        timeout_o;
  logic [31:0] fault_pc_o;

  int total;
  int fails;

  pc_gen_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .imem_ready_i      (imem_ready_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .fault_clear_i     (fault_clear_i),
`ifdef RVC_EN
    .is_compressed_i   (1'b0),
`endif
    .pc_out            (pc_out),
    .fire_o            (fire_o),
    .kill_o            (kill_o),
    .misalign_o        (misalign_o),
    .timeout_o         (timeout_o),
    .fault_pc_o        (fault_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst_n = 1'b0;
    stall_i = 1'b0;
    imem_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_target_i = 32'd0;
    fault_clear_i = 1'b0;
    step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_kill", {31'd0, kill_o}, 32'd0);
    chk("rst_flags", {30'd0, misalign_o, timeout_o}, 32'd0);
    chk("rst_fpc", fault_pc_o, 32'h0);

    rst_n = 1'b1;
    #1;
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_req", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("fetch0_pc", pc_out, 32'h0);
    chk("fetch0_req", {31'd0, imem_req_o}, 32'd1);
    chk("fetch0_addr", imem_addr_o, 32'h0);
    step();
    chk("fetch1_pc", pc_out, 32'h4);
    step();
    chk("fetch2_pc", pc_out, 32'h8);

    stall_i = 1'b1;
    #1;
    chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_to", {31'd0, timeout_o}, 32'd0);
    end
    stall_i = 1'b0;
    step();
    chk("resume_pc", pc_out, 32'hC);
    step();
    chk("pc_10", pc_out, 32'h10);

    redirect_i = 1'b1;
    redirect_target_i = 32'h200;
    #1;
    chk("redir_fire", {31'd0, fire_o}, 32'd0);
    step();
    redirect_i = 1'b0;
    chk("redir_pc", pc_out, 32'h200);
    chk("redir_kill", {31'd0, kill_o}, 32'd1);
    step();
    chk("redir_pc2", pc_out, 32'h204);
    chk("redir_kill2", {31'd0, kill_o}, 32'd0);

    redirect_i = 1'b1;
    redirect_target_i = 32'h202;
    step();
    redirect_i = 1'b0;
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_fpc", fault_pc_o, 32'h202);
    chk("mis_pc", pc_out, 32'h204);
    chk("mis_req", {31'd0, imem_req_o}, 32'd0);
    chk("mis_kill", {31'd0, kill_o}, 32'd1);
    redirect_i = 1'b1;
    redirect_target_i = 32'h300;
    step();
    redirect_i = 1'b0;
    chk("fault_ign_pc", pc_out, 32'h204);
    chk("fault_ign_kill", {31'd0, kill_o}, 32'd0);
    fault_clear_i = 1'b1;
    redirect_i = 1'b1;
    step();
    fault_clear_i = 1'b0;
    redirect_i = 1'b0;
    chk("clr_pc", pc_out, 32'h100);
    chk("clr_mis", {31'd0, misalign_o}, 32'd0);
    chk("clr_req", {31'd0, imem_req_o}, 32'd1);
    chk("clr_fpc", fault_pc_o, 32'h202);

    redirect_i = 1'b1;
    redirect_target_i = 32'h40;
    step();
    redirect_i = 1'b0;
    imem_ready_i = 1'b0;
    chk("to_start_pc", pc_out, 32'h40);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_wait", {31'd0, timeout_o}, 32'd0);
    end
    step();
    chk("to_flag", {31'd0, timeout_o}, 32'd1);
    chk("to_fpc", fault_pc_o, 32'h40);
    chk("to_req", {31'd0, imem_req_o}, 32'd0);
    fault_clear_i = 1'b1;
    step();
    fault_clear_i = 1'b0;
    chk("to_clr_pc", pc_out, 32'h100);
    chk("to_clr_flag", {31'd0, timeout_o}, 32'd0);

    redirect_i = 1'b1;
    redirect_target_i = 32'h40;
    step();
    redirect_i = 1'b0;
    for (int i = 1; i < 15; i++) begin
      step();
      chk("nto_wait", pc_out, 32'h40);
    end
    imem_ready_i = 1'b1;
    step();
    chk("nto_pc", pc_out, 32'h44);
    chk("nto_flag", {31'd0, timeout_o}, 32'd0);

    redirect_i = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap_start", pc_out, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_flags", {30'd0, misalign_o, timeout_o}, 32'd0);
    step();
    chk("wrap_next", pc_out, 32'h4);

    stall_i = 1'b1;
    step();
    chk("pre_rst_pc", pc_out, 32'h4);
    rst_n = 1'b0;
    #2;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_fpc", fault_pc_o, 32'h0);
    chk("arst_kill", {31'd0, kill_o}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
